// File: rtl/pico_intr_pkg.sv
// Shared types and register map for the KCPSM3 port-mapped interrupt controller.
// Optional feature macro: PICO_INTR_ROUND_ROBIN_EN (round-robin source selection).
package pico_intr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_e;

    localparam int unsigned ID_W = 3;

    localparam logic [1:0] OFS_PEND   = 2'd0;
    localparam logic [1:0] OFS_MASK   = 2'd1;
    localparam logic [1:0] OFS_ACTIVE = 2'd2;
    localparam logic [1:0] OFS_CLR    = 2'd3;

    localparam logic [7:0] ACTIVE_NONE = 8'hFF;

endpackage

// File: rtl/pico_intr_ctrl_if.sv
// KCPSM3 port bus plus interrupt handshake between processor (master) and controller (slave).
interface pico_intr_ctrl_if;

    logic [7:0] port_id;
    logic       write_strobe;
    logic [7:0] out_port;
    logic       interrupt_ack;
    logic       interrupt;
    logic [7:0] rd_data;
    logic       rd_hit;

    modport master (
        output port_id, write_strobe, out_port, interrupt_ack,
        input  interrupt, rd_data, rd_hit
    );

    modport slave (
        input  port_id, write_strobe, out_port, interrupt_ack,
        output interrupt, rd_data, rd_hit
    );

endinterface

// File: rtl/pico_intr_sel.sv
// Combinational source picker: lowest index wins, or round-robin after the last
// serviced id when PICO_INTR_ROUND_ROBIN_EN is defined.
module pico_intr_sel
    import pico_intr_pkg::*;
#(
    parameter int unsigned N_SRC = 4
) (
    input  logic [N_SRC-1:0] cand_i,
`ifdef PICO_INTR_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]  last_i,
`endif
    output logic             valid_o,
    output logic [ID_W-1:0]  id_o
);

`ifdef PICO_INTR_ROUND_ROBIN_EN
    logic [ID_W-1:0]    start;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum;
    logic [2*N_SRC-1:0] dbl;
    logic [N_SRC-1:0]   rot;

    // Rotate candidates so the search start lands at bit 0, then map back.
    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        off     = '0;
        start   = (last_i == ID_W'(N_SRC - 1)) ? '0 : last_i + 1'b1;
        dbl     = {cand_i, cand_i} >> start;
        rot     = dbl[N_SRC-1:0];
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!valid_o && rot[i]) begin
                valid_o = 1'b1;
                off     = ID_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (ID_W+1)'(N_SRC)) begin
            sum = sum - (ID_W+1)'(N_SRC);
        end
        id_o = sum[ID_W-1:0];
    end
`else
    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (cand_i[i-1]) begin
                valid_o = 1'b1;
                id_o    = ID_W'(i - 1);
            end
        end
    end
`endif

endmodule

// File: rtl/pico_intr_ctrl.sv
// Interrupt controller sharing the KCPSM3 interrupt line among N_SRC requesters.
// Define PICO_INTR_ROUND_ROBIN_EN for round-robin instead of fixed-priority selection.
module pico_intr_ctrl
    import pico_intr_pkg::*;
#(
    parameter int unsigned N_SRC     = 4,
    parameter logic [7:0]  BASE_ADDR = 8'h80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  req,
    pico_intr_ctrl_if.slave   bus
);

    state_e           state_q, state_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             intr_q, intr_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_hit_q, rd_hit_d;
`ifdef PICO_INTR_ROUND_ROBIN_EN
    logic [ID_W-1:0]  last_q, last_d;
`endif

    logic             hit;
    logic             wr_en;
    logic [1:0]       ofs;
    logic [N_SRC-1:0] wbits;
    logic             sel_valid;
    logic [ID_W-1:0]  sel_id;

    assign hit   = (bus.port_id[7:2] == BASE_ADDR[7:2]);
    assign ofs   = bus.port_id[1:0];
    assign wr_en = bus.write_strobe & hit;
    assign wbits = bus.out_port[N_SRC-1:0];

    pico_intr_sel #(.N_SRC(N_SRC)) u_sel (
        .cand_i  (pend_q & mask_q),
`ifdef PICO_INTR_ROUND_ROBIN_EN
        .last_i  (last_q),
`endif
        .valid_o (sel_valid),
        .id_o    (sel_id)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        pend_d  = pend_q;
        mask_d  = mask_q;
`ifdef PICO_INTR_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        if (wr_en && ofs == OFS_MASK) mask_d = wbits;
        if (wr_en && ofs == OFS_CLR)  pend_d = pend_d & ~wbits;

        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = REQ;
                    id_d    = sel_id;
                end
            end
            REQ: begin
                if (bus.interrupt_ack) begin
                    state_d        = SERVICE;
                    pend_d[id_q]   = 1'b0;
`ifdef PICO_INTR_ROUND_ROBIN_EN
                    last_d         = id_q;
`endif
                end
            end
            SERVICE: begin
                if (wr_en && ofs == OFS_ACTIVE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // New requests are applied last so they override both CLR and ack clears.
        pend_d = pend_d | req;
        intr_d = (state_d == REQ);

        rd_hit_d  = hit;
        rd_data_d = '0;
        if (hit) begin
            unique case (ofs)
                OFS_PEND:   rd_data_d[N_SRC-1:0] = pend_q;
                OFS_MASK:   rd_data_d[N_SRC-1:0] = mask_q;
                OFS_ACTIVE: rd_data_d = (state_q == SERVICE) ? 8'(id_q) : ACTIVE_NONE;
                default:    rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            mask_q    <= '0;
            id_q      <= '0;
            intr_q    <= 1'b0;
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
`ifdef PICO_INTR_ROUND_ROBIN_EN
            last_q    <= ID_W'(N_SRC - 1);
`endif
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
            intr_q    <= intr_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
`ifdef PICO_INTR_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.interrupt = intr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_hit    = rd_hit_q;

endmodule

// File: tb/tb_pico_intr_ctrl.sv
// Self-checking bench for pico_intr_ctrl: behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pico_intr_ctrl;

    localparam int         N    = 4;
    localparam logic [7:0] BASE = 8'h80;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;

    pico_intr_ctrl_if bus();

    pico_intr_ctrl #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: pending/mask as bit arrays, phase 0=idle, 1=awaiting ack, 2=in service.
    bit         m_pend [N];
    bit         m_mask [N];
    int         m_phase;
    int         m_id;
    int         m_last;
    bit         m_int;
    logic [7:0] m_rd;
    bit         m_hit;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        int start;
`ifdef PICO_INTR_ROUND_ROBIN_EN
        start = (m_last + 1) % N;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) begin
            int s;
            s = (start + k) % N;
            if (m_pend[s] && m_mask[s]) return s;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int a;
        int pk;
        bit wr;
        bit np [N];
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_mask[i] = 1'b0;
            end
            m_phase = 0;
            m_id    = 0;
            m_last  = N - 1;
            m_int   = 1'b0;
            m_rd    = 8'h00;
            m_hit   = 1'b0;
        end else begin
            a     = int'(bus.port_id) - int'(BASE);
            m_hit = (a >= 0 && a < 4);
            wr    = m_hit && bus.write_strobe;
            m_rd  = 8'h00;
            if (m_hit) begin
                case (a)
                    0: for (int i = 0; i < N; i++) m_rd[i] = m_pend[i];
                    1: for (int i = 0; i < N; i++) m_rd[i] = m_mask[i];
                    2: m_rd = (m_phase == 2) ? 8'(m_id) : 8'hFF;
                    default: m_rd = 8'h00;
                endcase
            end
            pk = pick();
            for (int i = 0; i < N; i++) np[i] = m_pend[i];
            if (wr && a == 3)
                for (int i = 0; i < N; i++) if (bus.out_port[i]) np[i] = 1'b0;
            if (wr && a == 1)
                for (int i = 0; i < N; i++) m_mask[i] = bus.out_port[i];
            case (m_phase)
                0: if (pk >= 0) begin m_phase = 1; m_id = pk; end
                1: if (bus.interrupt_ack) begin m_phase = 2; np[m_id] = 1'b0; m_last = m_id; end
                default: if (wr && a == 2) m_phase = 0;
            endcase
            for (int i = 0; i < N; i++) if (req[i]) np[i] = 1'b1;
            for (int i = 0; i < N; i++) m_pend[i] = np[i];
            m_int = (m_phase == 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_interrupt", {7'b0, bus.interrupt}, {7'b0, m_int});
            chk("model_rd_hit", {7'b0, bus.rd_hit}, {7'b0, m_hit});
            chk("model_rd_data", bus.rd_data, m_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] d);
        bus.port_id      = addr;
        bus.out_port     = d;
        bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
        bus.port_id      = 8'h00;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [7:0] v, output logic h);
        bus.port_id = addr;
        tick();
        v = bus.rd_data;
        h = bus.rd_hit;
        bus.port_id = 8'h00;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] v;
        logic       h;
        rd(addr, v, h);
        chk(name, v, exp);
    endtask

    task automatic ack();
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] r);
        req = r;
        tick();
        req = '0;
    endtask

    task automatic wait_int(input string name);
        int n;
        n = 0;
        while (bus.interrupt !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, {7'b0, bus.interrupt}, 8'h01);
    endtask

    task automatic eoi();
        wr(BASE + 8'd2, 8'h00);
    endtask

    initial begin
        logic [7:0] v;
        logic       h;
        reset             = 1'b1;
        req               = '0;
        bus.port_id       = 8'h00;
        bus.write_strobe  = 1'b0;
        bus.out_port      = 8'h00;
        bus.interrupt_ack = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_interrupt", {7'b0, bus.interrupt}, 8'h00);
        chk("reset_rd_data", bus.rd_data, 8'h00);
        chk("reset_rd_hit", {7'b0, bus.rd_hit}, 8'h00);

        // Single pulse on source 2
        wr(BASE + 8'd1, 8'h0F);
        pulse(4'b0100);
        rd_chk("pend_after_pulse", BASE, 8'h04);
        chk("int_two_after_pulse", {7'b0, bus.interrupt}, 8'h01);
        ack();
        chk("int_low_after_ack", {7'b0, bus.interrupt}, 8'h00);
        rd_chk("active_src2", BASE + 8'd2, 8'h02);
        rd_chk("pend_cleared", BASE, 8'h00);
        eoi();
        rd_chk("active_none", BASE + 8'd2, 8'hFF);

        // Two simultaneous requests
        pulse(4'b1010);
        wait_int("int_0a_first");
        ack();
        rd_chk("first_of_0a", BASE + 8'd2, 8'h01);
        eoi();
        wait_int("int_0a_second");
        ack();
        rd_chk("second_of_0a", BASE + 8'd2, 8'h03);
        eoi();
        pulse(4'b0011);
        wait_int("int_03_first");
        ack();
        rd_chk("first_of_03", BASE + 8'd2, 8'h00);
        eoi();
        wait_int("int_03_second");
        ack();
        rd_chk("second_of_03", BASE + 8'd2, 8'h01);
        eoi();

        // Masked request becomes visible after unmasking
        wr(BASE + 8'd1, 8'h00);
        pulse(4'b0001);
        tick();
        tick();
        chk("masked_no_int", {7'b0, bus.interrupt}, 8'h00);
        rd_chk("masked_pend", BASE, 8'h01);
        wr(BASE + 8'd1, 8'h01);
        chk("unmask_not_yet", {7'b0, bus.interrupt}, 8'h00);
        tick();
        chk("unmask_int", {7'b0, bus.interrupt}, 8'h01);
        ack();
        eoi();
        wr(BASE + 8'd1, 8'h0F);

        // Request on the locked source in the same cycle as ack stays pending
        pulse(4'b0100);
        wait_int("int_src2_again");
        req = 4'b0100;
        ack();
        req = '0;
        rd_chk("req_with_ack_pend", BASE, 8'h04);
        eoi();
        wait_int("int_src2_repend");
        ack();
        rd_chk("pend_after_reack", BASE, 8'h00);
        eoi();

        // req and CLR on the same bit during SERVICE
        pulse(4'b0001);
        wait_int("int_src0");
        ack();
        bus.port_id      = BASE + 8'd3;
        bus.out_port     = 8'h02;
        bus.write_strobe = 1'b1;
        req              = 4'b0010;
        tick();
        bus.write_strobe = 1'b0;
        bus.port_id      = 8'h00;
        req              = '0;
        rd_chk("set_beats_clr", BASE, 8'h02);
        tick();
        chk("no_int_in_service", {7'b0, bus.interrupt}, 8'h00);
        eoi();
        chk("no_int_at_eoi", {7'b0, bus.interrupt}, 8'h00);
        tick();
        chk("int_after_eoi", {7'b0, bus.interrupt}, 8'h01);

        // Reset while in REQ
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_req_int", {7'b0, bus.interrupt}, 8'h00);
        rd_chk("rst_req_pend", BASE, 8'h00);
        rd_chk("rst_req_mask", BASE + 8'd1, 8'h00);
        rd_chk("rst_req_active", BASE + 8'd2, 8'hFF);

        // Upper mask bits are ignored
        wr(BASE + 8'd1, 8'hFF);
        rd_chk("mask_upper_bits", BASE + 8'd1, 8'h0F);

        // Address sweep
        for (int a = 0; a < 5; a++) begin
            rd(BASE + 8'(a), v, h);
            chk("sweep_hit", {7'b0, h}, (a < 4) ? 8'h01 : 8'h00);
            if (a == 3) chk("clr_reads_zero", v, 8'h00);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req               = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            bus.interrupt_ack = ($urandom_range(0, 3) == 0);
            bus.write_strobe  = ($urandom_range(0, 4) == 0);
            bus.port_id       = 8'h7E + 8'($urandom_range(0, 7));
            bus.out_port      = 8'($urandom);
            reset             = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset             = 1'b0;
        req               = '0;
        bus.interrupt_ack = 1'b0;
        bus.write_strobe  = 1'b0;
        bus.port_id       = 8'h00;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
